// File: rtl/motor_hbridge_drv.sv
// L298-style H-bridge driver: direction FSM with reversal dead-time plus shadowed PWM on EN.
// Optional STATUS register and reversal counter when MOTOR_HB_STATUS_EN is defined.
module motor_hbridge_drv #(
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  dir_in,
    output logic        hb_in1,
    output logic        hb_in2,
    output logic        hb_en
);

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    logic           wr_en;
    logic [CW-1:0]  period_sh;
    logic [CW-1:0]  duty_sh;
    logic [CW-1:0]  period_act;
    logic [CW-1:0]  duty_act;
    logic [CW-1:0]  cnt;
    logic           cnt_wrap;
    logic           load_act;
    logic           pwm;
    logic [DTW-1:0] dead_reg;
    logic [DTW-1:0] dcnt;
    logic [DTW-1:0] dcnt_nxt;
    logic [1:0]     dsync_meta;
    logic [1:0]     dsync;
    logic           want_rev;
    logic           tgt_rev;
    logic           tgt_rev_nxt;
    state_t         state;
    state_t         state_nxt;
    logic           in1_nxt;
    logic           in2_nxt;
    logic           en_nxt;

    assign wr_en = chipselect && !write_n;

    // Host-visible registers; PERIOD/DUTY only reach the counter through the active copies.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_sh <= '0;
            duty_sh   <= '0;
            dead_reg  <= DTW'(50);
        end else if (wr_en) begin
            case (address)
                2'd0:    period_sh <= writedata[CW-1:0];
                2'd1:    duty_sh   <= writedata[CW-1:0];
                2'd2:    dead_reg  <= writedata[DTW-1:0];
                default: ;
            endcase
        end
    end

    generate
        if (CW < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:CW];
        end
    endgenerate

    // Active copies reload only at a period boundary, or continuously while idle (PERIOD 0).
    assign cnt_wrap = (period_act != '0) && (cnt == period_act - CW'(1));
    assign load_act = (period_act == '0) || cnt_wrap;
    assign pwm      = (period_act != '0) && (cnt < duty_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_act <= '0;
            duty_act   <= '0;
            cnt        <= '0;
        end else begin
            if (load_act) begin
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end
            if (load_act) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsync_meta <= 2'b00;
            dsync      <= 2'b00;
        end else begin
            dsync_meta <= dir_in;
            dsync      <= dsync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_COAST;
            tgt_rev <= 1'b0;
            dcnt    <= '0;
        end else begin
            state   <= state_nxt;
            tgt_rev <= tgt_rev_nxt;
            dcnt    <= dcnt_nxt;
        end
    end

    assign want_rev = dsync[1];

    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    always_comb begin
        state_nxt   = state;
        tgt_rev_nxt = tgt_rev;
        dcnt_nxt    = dcnt;
        case (dsync)
            2'b00: state_nxt = ST_COAST;
            2'b11: state_nxt = ST_BRAKE;
            default: begin
                if (state == ST_DEAD) begin
                    if (tgt_rev != want_rev) begin
                        // Direction flipped again mid-coast: restart the full dead-time.
                        tgt_rev_nxt = want_rev;
                        dcnt_nxt    = dead_reg;
                    end else if (dcnt == '0) begin
                        state_nxt = want_rev ? ST_REV : ST_FWD;
                    end else begin
                        dcnt_nxt = dcnt - DTW'(1);
                    end
                end else if ((state == ST_FWD && want_rev) || (state == ST_REV && !want_rev)) begin
                    state_nxt   = ST_DEAD;
                    tgt_rev_nxt = want_rev;
                    dcnt_nxt    = dead_reg;
                end else begin
                    state_nxt = want_rev ? ST_REV : ST_FWD;
                end
            end
        endcase
    end

    // Pins are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        in1_nxt = 1'b0;
        in2_nxt = 1'b0;
        en_nxt  = 1'b0;
        case (state_nxt)
            ST_FWD: begin
                in1_nxt = 1'b1;
                en_nxt  = pwm;
            end
            ST_REV: begin
                in2_nxt = 1'b1;
                en_nxt  = pwm;
            end
            ST_BRAKE: begin
                in1_nxt = 1'b1;
                in2_nxt = 1'b1;
                en_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_in1 <= 1'b0;
            hb_in2 <= 1'b0;
            hb_en  <= 1'b0;
        end else begin
            hb_in1 <= in1_nxt;
            hb_in2 <= in2_nxt;
            hb_en  <= en_nxt;
        end
    end

`ifdef MOTOR_HB_STATUS_EN
    logic [7:0] rev_cnt;
    logic       dead_entry;

    assign dead_entry = (state_nxt == ST_DEAD) && (state != ST_DEAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rev_cnt <= 8'd0;
        end else if (wr_en && address == 2'd3) begin
            rev_cnt <= 8'd0;
        end else if (dead_entry && rev_cnt != 8'hFF) begin
            rev_cnt <= rev_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[CW-1:0]  = period_sh;
            2'd1: readdata[CW-1:0]  = duty_sh;
            2'd2: readdata[DTW-1:0] = dead_reg;
            default: begin
`ifdef MOTOR_HB_STATUS_EN
                readdata = {16'b0, rev_cnt, 3'b0, state, dsync};
`else
                readdata = '0;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_motor_hbridge_drv.sv
// Self-checking bench for motor_hbridge_drv: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the direction and PWM rules.
module tb_motor_hbridge_drv;

    localparam int CW  = 16;
    localparam int DTW = 8;

    localparam int M_COAST = 0;
    localparam int M_FWD   = 1;
    localparam int M_REV   = 2;
    localparam int M_BRAKE = 3;
    localparam int M_DEAD  = 4;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  dir_in     = 2'b00;
    logic        hb_in1;
    logic        hb_in2;
    logic        hb_en;
    logic [2:0]  outs;

    assign outs = {hb_in1, hb_in2, hb_en};

    motor_hbridge_drv #(.CW(CW), .DTW(DTW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dir_in     (dir_in),
        .hb_in1     (hb_in1),
        .hb_in2     (hb_in2),
        .hb_en      (hb_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state (plain integers, updated once per rising edge)
    int         m_s1, m_dsync;
    int         m_mode, m_tgt, m_left, m_rev;
    int         m_psh, m_dsh, m_dead;
    int         m_period, m_duty, m_cnt;
    logic [2:0] m_out = 3'b000;

    task automatic model_reset();
        m_s1 = 0;  m_dsync = 0;
        m_mode = M_COAST; m_tgt = M_FWD; m_left = 0; m_rev = 0;
        m_psh = 0; m_dsh = 0; m_dead = 50;
        m_period = 0; m_duty = 0; m_cnt = 0;
        m_out = 3'b000;
    endtask

    task automatic model_step();
        bit pwm;
        int want;
        pwm = (m_period != 0) && (m_cnt < m_duty);
        if (m_dsync == 0) begin
            m_mode = M_COAST;
        end else if (m_dsync == 3) begin
            m_mode = M_BRAKE;
        end else begin
            want = (m_dsync == 1) ? M_FWD : M_REV;
            if (m_mode == M_DEAD) begin
                if (want != m_tgt) begin
                    m_tgt  = want;
                    m_left = m_dead;
                end else if (m_left == 0) begin
                    m_mode = want;
                end else begin
                    m_left--;
                end
            end else if ((m_mode == M_FWD || m_mode == M_REV) && m_mode != want) begin
                m_mode = M_DEAD;
                m_tgt  = want;
                m_left = m_dead;
                if (m_rev < 255) m_rev++;
            end else begin
                m_mode = want;
            end
        end
        case (m_mode)
            M_FWD:   m_out = {1'b1, 1'b0, pwm};
            M_REV:   m_out = {1'b0, 1'b1, pwm};
            M_BRAKE: m_out = 3'b111;
            default: m_out = 3'b000;
        endcase
        if (m_period == 0 || m_cnt == m_period - 1) begin
            m_cnt    = 0;
            m_period = m_psh;
            m_duty   = m_dsh;
        end else begin
            m_cnt++;
        end
        if (chipselect && !write_n) begin
            case (address)
                2'd0:    m_psh  = int'(writedata[CW-1:0]);
                2'd1:    m_dsh  = int'(writedata[CW-1:0]);
                2'd2:    m_dead = int'(writedata[DTW-1:0]);
                default: m_rev  = 0;
            endcase
        end
        m_dsync = m_s1;
        m_s1    = int'(dir_in);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = 32'(m_psh);
            2'd1: r = 32'(m_dsh);
            2'd2: r = 32'(m_dead);
            default: begin
`ifdef MOTOR_HB_STATUS_EN
                r = {16'b0, 8'(m_rev), 3'b0, 3'(m_mode), 2'(m_dsync)};
`else
                r = 32'd0;
`endif
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Every falling edge: pins against the model, and the shoot-through rule.
    logic [1:0] prev_pair = 2'b00;
    always @(negedge clk) begin
        check("out", 32'(outs), 32'(m_out));
        check("shoot", 32'((prev_pair == 2'b10 && outs[2:1] == 2'b01) ||
                           (prev_pair == 2'b01 && outs[2:1] == 2'b10)), 32'd0);
        prev_pair <= outs[2:1];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Caller is at a falling edge; the write is seen by exactly one rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wait_rise(input string tag);
        int   k;
        logic prev;
        prev = hb_en;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (hb_en && !prev) break;
            prev = hb_en;
        end
        check(tag, 32'(k < 400), 32'd1);
    endtask

    int n;

    initial begin
        // Reset held with forward requested
        #1 reset_n = 1'b0;
        dir_in = 2'b01;
        repeat (3) @(negedge clk);
        address = 2'd0;
        #1 check("rd_rst", readdata, 32'd0);
        check("out_rst", 32'(outs), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("fwd_release", 32'(outs), 32'b100);

        // PWM 25 of 100
        wr(2'd0, 32'd100);
        wr(2'd1, 32'd25);
        repeat (250) @(negedge clk);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            n += int'(hb_en);
        end
        check("pwm25", 32'(n), 32'd25);
        address = 2'd0; #1 check("rd_period", readdata, 32'd100);
        address = 2'd1; #1 check("rd_duty", readdata, 32'd25);
        address = 2'd2; #1 check("rd_dead", readdata, 32'd50);
        @(negedge clk);

        // Shadow: DUTY written mid-pulse only takes effect after the wrap
        wait_rise("rise_old");
        n = 1;
        repeat (5) begin
            @(negedge clk);
            n += int'(hb_en);
        end
        wr(2'd1, 32'd50);
        n += int'(hb_en);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!hb_en) break;
            n++;
        end
        check("shadow_old", 32'(n), 32'd25);
        wait_rise("rise_new");
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!hb_en) break;
            n++;
        end
        check("shadow_new", 32'(n), 32'd50);

        // Full duty, then a reversal with DEAD=10
        wr(2'd2, 32'd10);
        wr(2'd1, 32'd100);
        repeat (250) @(negedge clk);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            n += int'(hb_en);
        end
        check("duty_full", 32'(n), 32'd100);
        dir_in = 2'b10;
        repeat (2) @(negedge clk);
        check("rev_pre", 32'(outs), 32'b101);
        @(negedge clk);
        check("rev_dead0", 32'(outs), 32'b000);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (outs != 3'b000) break;
            n++;
        end
        check("dead_len", 32'(n), 32'd11);
        check("rev_out", 32'(outs), 32'b011);

        // Abort dead-time with brake, then coast
        dir_in = 2'b01;
        repeat (7) @(negedge clk);
        check("abort_dead", 32'(outs), 32'b000);
        dir_in = 2'b11;
        repeat (2) @(negedge clk);
        check("brake_pre", 32'(outs), 32'b000);
        @(negedge clk);
        check("brake", 32'(outs), 32'b111);
        dir_in = 2'b00;
        repeat (2) @(negedge clk);
        check("coast_pre", 32'(outs), 32'b111);
        @(negedge clk);
        check("coast", 32'(outs), 32'b000);

`ifdef MOTOR_HB_STATUS_EN
        wr(2'd3, 32'd0);
        dir_in = 2'b01; repeat (6) @(negedge clk);
        dir_in = 2'b10; repeat (20) @(negedge clk);
        dir_in = 2'b01; repeat (20) @(negedge clk);
        dir_in = 2'b10; repeat (20) @(negedge clk);
        address = 2'd3;
        #1 check("st_rev", 32'(readdata[15:8]), 32'd3);
        check("st_state", 32'(readdata[4:2]), 32'd2);
        check("st_dsync", 32'(readdata[1:0]), 32'd2);
        @(negedge clk);
        wr(2'd3, 32'd0);
        address = 2'd3;
        #1 check("st_clr", 32'(readdata[15:8]), 32'd0);
        @(negedge clk);
`else
        address = 2'd3;
        #1 check("st_zero", readdata, 32'd0);
        @(negedge clk);
        wr(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        #1 check("st_zero_wr", readdata, 32'd0);
        @(negedge clk);
`endif

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 4000; i++) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
            if ($urandom_range(0, 5) == 0) dir_in = 2'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                case (address)
                    2'd0:    writedata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 20);
                    2'd1:    writedata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 24);
                    2'd2:    writedata = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 6);
                    default: writedata = $urandom;
                endcase
            end
            #1 check("rd_rand", readdata, model_rd(address));
            if (i == 2000) begin
                #2 reset_n = 1'b0;
                #1 check("async_rst", 32'(outs), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
